// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache: FSM state type, default
// geometry, the tag-width function and address field-extract helpers.
// Addresses are 16-bit word addresses laid out as {tag, index, offset}.
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ADDR_BITS       = 16;
    localparam int DEF_INDEX_BITS  = 3;
    localparam int DEF_OFFSET_BITS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int tag_bits(input int index_bits, input int offset_bits);
        return ADDR_BITS - index_bits - offset_bits;
    endfunction

    // Field helpers return the field right-justified in a full-width word;
    // callers size-cast to the field width they need.
    function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr,
                                                      input int index_bits,
                                                      input int offset_bits);
        return addr >> (index_bits + offset_bits);
    endfunction

    function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr,
                                                        input int index_bits,
                                                        input int offset_bits);
        return (addr >> offset_bits) & ((16'd1 << index_bits) - 16'd1);
    endfunction

    function automatic logic [ADDR_BITS-1:0] addr_offset(input logic [ADDR_BITS-1:0] addr,
                                                         input int offset_bits);
        return addr & ((16'd1 << offset_bits) - 16'd1);
    endfunction

    // Line-aligned base address: offset field forced to zero.
    function automatic logic [ADDR_BITS-1:0] line_base(input logic [ADDR_BITS-1:0] addr,
                                                       input int offset_bits);
        return addr & ~((16'd1 << offset_bits) - 16'd1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Valid / tag / data storage for the direct-mapped instruction cache.
//   clk, rst            : clock, synchronous active-high reset (clears valids)
//   rd_idx, rd_off      : combinational read port address
//   rd_valid, rd_tag    : valid bit and stored tag of line rd_idx
//   rd_data             : word rd_off of line rd_idx
//   wr_en, wr_idx,
//   wr_off, wr_data     : single-word data write port (fill beats)
//   tag_we, tag_wdata   : install tag of line wr_idx and set its valid bit
//   inv_all             : clear every valid bit (wins over tag_we)
// -----------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter  int INDEX_BITS  = DEF_INDEX_BITS,
    parameter  int OFFSET_BITS = DEF_OFFSET_BITS,
    localparam int TAG_BITS    = tag_bits(INDEX_BITS, OFFSET_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_idx,
    input  logic [OFFSET_BITS-1:0] rd_off,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [15:0]            rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_idx,
    input  logic [OFFSET_BITS-1:0] wr_off,
    input  logic [15:0]            wr_data,
    input  logic                   tag_we,
    input  logic [TAG_BITS-1:0]    tag_wdata,
    input  logic                   inv_all
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [15:0]         data [LINES][WORDS];

    // Invalidate has priority over installing a line, so a pending
    // invalidate that coincides with the last fill beat drops that line too.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately left without reset; the
    // valid bits alone qualify their contents, and resetting a storage array
    // would prevent it from mapping onto plain storage cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tags[wr_idx] <= tag_wdata;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx][rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped, read-only instruction cache between the IF fetch port and a
// multi-cycle main memory. Hits return in the same cycle; a miss stalls IF
// while the whole line is fetched one word per mem_rdy beat.
//   clk, rst     : clock, synchronous active-high reset
//   if_addr      : fetch word address (PC)
//   if_re        : fetch request this cycle
//   inv_all      : one-cycle pulse, invalidate every line
//   instr        : fetched word, valid when if_re & ~stall
//   stall        : miss in progress, IF holds its PC
//   mem_re       : line-fill request, high for the whole fill
//   mem_addr     : line-aligned fill address
//   mem_rdy      : memory beat strobe, ascending word order
//   mem_rdata    : beat data
// -----------------------------------------------------------------------------
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    input  logic        if_re,
    input  logic        inv_all,
    output logic [15:0] instr,
    output logic        stall,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);

    state_t                 state;
    logic [OFFSET_BITS-1:0] beat_cnt;
    logic                   inv_pend;
    logic [15:0]            fill_addr;

    logic [INDEX_BITS-1:0]  lk_idx;
    logic [OFFSET_BITS-1:0] lk_off;
    logic [TAG_BITS-1:0]    lk_tag;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   line_valid;
    logic [TAG_BITS-1:0]    line_tag;
    logic                   hit;
    logic                   miss;
    logic                   beat;
    logic                   last_beat;
    logic                   clr_valid;

    assign lk_idx   = INDEX_BITS'(addr_index(if_addr, INDEX_BITS, OFFSET_BITS));
    assign lk_off   = OFFSET_BITS'(addr_offset(if_addr, OFFSET_BITS));
    assign lk_tag   = TAG_BITS'(addr_tag(if_addr, INDEX_BITS, OFFSET_BITS));
    assign fill_idx = INDEX_BITS'(addr_index(fill_addr, INDEX_BITS, OFFSET_BITS));
    assign fill_tag = TAG_BITS'(addr_tag(fill_addr, INDEX_BITS, OFFSET_BITS));

    assign hit       = line_valid && (line_tag == lk_tag);
    assign miss      = (state == IDLE) && if_re && !hit;
    assign beat      = (state == FILL) && mem_rdy;
    assign last_beat = beat && (beat_cnt == '1);

    // An invalidate seen during a fill is deferred to the final beat so the
    // line being installed is dropped along with everything else.
    assign clr_valid = ((state == IDLE) && inv_all) ||
                       (last_beat && (inv_pend || inv_all));

    // Lookup in the invalidate cycle still sees the old valids; stall must
    // be combinational so a hit costs no added latency.
    assign stall    = !rst && ((state == FILL) || (if_re && !hit));
    assign mem_addr = fill_addr;

    icache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (lk_idx),
        .rd_off    (lk_off),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (instr),
        .wr_en     (beat),
        .wr_idx    (fill_idx),
        .wr_off    (beat_cnt),
        .wr_data   (mem_rdata),
        .tag_we    (last_beat),
        .tag_wdata (fill_tag),
        .inv_all   (clr_valid)
    );

    // NOTE: all state here is sequential and updated with non-blocking
    // assignments, so every branch reads the pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            inv_pend  <= 1'b0;
            fill_addr <= '0;
            mem_re    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        fill_addr <= line_base(if_addr, OFFSET_BITS);
                        beat_cnt  <= '0;
                        mem_re    <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (inv_all) begin
                        inv_pend <= 1'b1;
                    end
                    if (beat) begin
                        // Wraps back to zero exactly on the final beat.
                        beat_cnt <= beat_cnt + OFFSET_BITS'(1);
                    end
                    if (last_beat) begin
                        state    <= IDLE;
                        mem_re   <= 1'b0;
                        inv_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Self-checking bench for icache_ctrl. A behavioural memory answers fills
// with word(a) = a ^ 16'hA010 (so line 0x0010 holds 0xA000..0xA003), with a
// programmable beat spacing. Expected fetch words are queued when a fetch is
// driven and compared when the cache delivers (if_re & ~stall).
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_addr;
    logic        if_re;
    logic        inv_all;
    logic [15:0] instr;
    logic        stall;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_re     (if_re),
        .inv_all   (inv_all),
        .instr     (instr),
        .stall     (stall),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    int          gap     = 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA010;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: strobes every 'gap' cycles while mem_re is high, words in
    // ascending order from mem_addr; a dropped mem_re restarts the line.
    initial begin
        int beat_no = 0;
        int gap_cnt = 0;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_re) begin
                beat_no = 0;
                gap_cnt = 0;
                mem_rdy = 1'b0;
            end else begin
                if (mem_rdy) beat_no++;
                if (gap_cnt == gap - 1) begin
                    mem_rdy = 1'b1;
                    gap_cnt = 0;
                end else begin
                    mem_rdy = 1'b0;
                    gap_cnt++;
                end
            end
            mem_rdata = mem_word(mem_addr + 16'(beat_no));
        end
    end

    // One fetch from IDLE until delivery. inv_at pulses inv_all in that
    // cycle of the fetch (-1 for none). Counts stall and mem_re cycles and
    // checks mem_addr in every mem_re cycle.
    task automatic fetch(input string name, input logic [15:0] a, input int g,
                         input int inv_at, input int exp_stall, input int exp_mre,
                         input logic [15:0] exp_ma);
        int stall_n = 0;
        int mre_n   = 0;
        int ma_bad  = 0;
        bit done    = 1'b0;
        gap     = g;
        if_addr = a;
        if_re   = 1'b1;
        exp_q.push_back(mem_word(a));
        for (int c = 0; c < 200 && !done; c++) begin
            inv_all = (c == inv_at);
            @(negedge clk);
            if (mem_re) begin
                mre_n++;
                if (mem_addr !== exp_ma) ma_bad++;
            end
            if (stall) begin
                stall_n++;
            end else begin
                check({name, " instr"}, 32'(instr), 32'(exp_q.pop_front()));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        inv_all = 1'b0;
        check({name, " delivered"}, 32'(done), 32'd1);
        if (!done) void'(exp_q.pop_front());
        check({name, " stall cycles"}, stall_n, exp_stall);
        check({name, " mem_re cycles"}, mre_n, exp_mre);
        check({name, " bad mem_addr cycles"}, ma_bad, 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        int          gap;
        int          inv_at;
        int          stall;
        int          mre;
        logic [15:0] ma;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int nb;
        int bad;
        int stall_n;
        bit done;

        //            addr      gap inv  stall mre  mem_addr
        vecs[0]  = '{16'h0012, 1, -1,  5,  4, 16'h0010};  // cold miss
        vecs[1]  = '{16'h0010, 1, -1,  0,  0, 16'h0000};  // hits after fill
        vecs[2]  = '{16'h0011, 1, -1,  0,  0, 16'h0000};
        vecs[3]  = '{16'h0013, 1, -1,  0,  0, 16'h0000};
        vecs[4]  = '{16'h0090, 1, -1,  5,  4, 16'h0090};  // conflict, index 4
        vecs[5]  = '{16'h0091, 1, -1,  0,  0, 16'h0000};
        vecs[6]  = '{16'h0012, 1, -1,  5,  4, 16'h0010};  // evicted, misses again
        vecs[7]  = '{16'h0022, 3, -1, 13, 12, 16'h0020};  // beats every 3rd cycle
        vecs[8]  = '{16'h0020, 1, -1,  0,  0, 16'h0000};
        vecs[9]  = '{16'h0021, 1, -1,  0,  0, 16'h0000};
        vecs[10] = '{16'h0023, 1, -1,  0,  0, 16'h0000};
        vecs[11] = '{16'h0010, 1,  0,  0,  0, 16'h0000};  // inv in IDLE, old valids used
        vecs[12] = '{16'h0020, 1, -1,  5,  4, 16'h0020};  // invalidated
        vecs[13] = '{16'h0010, 1,  2, 10,  8, 16'h0010};  // inv mid-fill: refill twice
        vecs[14] = '{16'h0010, 1, -1,  0,  0, 16'h0000};  // pending inv consumed
        vecs[15] = '{16'h0020, 1, -1,  5,  4, 16'h0020};  // cleared by pending inv

        // Reset state, with a fetch request present during reset.
        rst     = 1'b1;
        if_re   = 1'b1;
        if_addr = 16'h0012;
        inv_all = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset mem_re", 32'(mem_re), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        if_re = 1'b0;
        @(negedge clk);
        check("idle no request stall", 32'(stall), 32'd0);
        check("idle no request mem_re", 32'(mem_re), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].gap, vecs[i].inv_at,
                  vecs[i].stall, vecs[i].mre, vecs[i].ma);
        end

        // Reset during the second beat of a fill of line 0x0050.
        gap     = 1;
        if_addr = 16'h0052;
        if_re   = 1'b1;
        exp_q.push_back(mem_word(16'h0052));
        @(negedge clk);
        check("rst seq miss stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst seq stall under rst", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst seq mem_re after rst", 32'(mem_re), 32'd0);
        check("rst seq line invalid", 32'(stall), 32'd1);
        stall_n = 0;
        done    = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (stall) begin
                stall_n++;
            end else begin
                check("rst seq refill instr", 32'(instr), 32'(exp_q.pop_front()));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("rst seq delivered", 32'(done), 32'd1);
        if (!done) void'(exp_q.pop_front());
        check("rst seq refill stall cycles", stall_n, 5);

        // Redirect to 0x0100 one cycle into the fill of line 0x0010.
        if_addr = 16'h0010;
        if_re   = 1'b1;
        @(negedge clk);
        check("redirect first miss", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        if_addr = 16'h0100;
        exp_q.push_back(mem_word(16'h0100));
        na   = 0;
        nb   = 0;
        bad  = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_re) begin
                if (mem_addr === 16'h0010) begin
                    if (nb > 0) bad++;
                    na++;
                end else if (mem_addr === 16'h0100) begin
                    nb++;
                end else begin
                    bad++;
                end
            end
            if (!stall) begin
                check("redirect instr", 32'(instr), 32'(exp_q.pop_front()));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("redirect delivered", 32'(done), 32'd1);
        if (!done) void'(exp_q.pop_front());
        check("redirect cycles on 0x0010", na, 4);
        check("redirect cycles on 0x0100", nb, 4);
        check("redirect bad mem_addr cycles", bad, 0);
        fetch("redirect line kept", 16'h0013, 1, -1, 0, 0, 16'h0000);

        if_re = 1'b0;
        check("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
